// File: rtl/traffic_pkg.sv
// traffic_pkg: shared phase encoding and default timing for the traffic phase scheduler
package traffic_pkg;
    typedef enum logic [1:0] {IDLE, GREEN, YELLOW, ALLRED} phase_t;
    localparam int N_REQ        = 16;
    localparam int GREEN_TICKS  = 5;
    localparam int YELLOW_TICKS = 2;
    localparam int ALLRED_TICKS = 1;
    localparam int CNT_W        = 4;
endpackage

// File: rtl/rr_pick16.sv
// rr_pick16: round-robin pick of the first pending source after last, wrapping 15->0
//  pending [15:0] in  - pending request bits
//  last    [3:0]  in  - most recently granted source; search starts at last+1
//  valid          out - any bit pending
//  idx     [3:0]  out - selected source
module rr_pick16 (
    input  logic [15:0] pending,
    input  logic [3:0]  last,
    output logic        valid,
    output logic [3:0]  idx
);
    logic [15:0] rot;
    logic [3:0]  off;
    // rot[i] is the source i+1 places after last, so the lowest set bit is the winner
    always_comb begin
        rot = '0;
        off = '0;
        for (int i = 0; i < 16; i++) rot[i] = pending[last + 4'(i) + 4'd1];
        for (int i = 15; i >= 0; i--) if (rot[i]) off = 4'(i);
    end
    assign valid = |pending;
    assign idx   = last + off + 4'd1;
endmodule

// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: round-robin sharing of one green phase among 16 request sources
//  clk          in  - system clock, rising edge
//  reset        in  - asynchronous active-high, clears all state
//  tick         in  - timing strobe; phase counters advance only on tick
//  req     [15] in  - request per source, latched into pending
//  green   [15] out - one-hot green of granted source
//  yellow  [15] out - one-hot yellow of source being cleared
//  any_pending  out - OR of the pending register
//  busy         out - high in GREEN, YELLOW and ALLRED
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int GREEN_TICKS  = traffic_pkg::GREEN_TICKS,
    parameter int YELLOW_TICKS = traffic_pkg::YELLOW_TICKS,
    parameter int ALLRED_TICKS = traffic_pkg::ALLRED_TICKS,
    parameter int CNT_W        = traffic_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] green,
    output logic [N_REQ-1:0] yellow,
    output logic             any_pending,
    output logic             busy
);
    phase_t             state, state_n;
    logic [N_REQ-1:0]   pending, clr;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [3:0]         grant, grant_n, last, last_n, idx;
    logic               valid, ph_end;

    rr_pick16 u_pick (.pending(pending), .last(last), .valid(valid), .idx(idx));

    assign ph_end = tick && cnt == (state == GREEN  ? CNT_W'(GREEN_TICKS - 1) :
                                    state == YELLOW ? CNT_W'(YELLOW_TICKS - 1) :
                                                      CNT_W'(ALLRED_TICKS - 1));

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        grant_n = grant;
        last_n  = last;
        clr     = '0;
        if (state == IDLE || (state == ALLRED && ph_end)) begin
            state_n = valid ? GREEN : IDLE;
            cnt_n   = '0;
            if (valid) begin
                grant_n = idx;
                last_n  = idx;
                clr     = N_REQ'(1) << idx;
            end
        end else if (ph_end) begin
            state_n = state == GREEN ? YELLOW : ALLRED;
            cnt_n   = '0;
        end else if (tick) begin
            cnt_n = cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            pending <= '0;
            cnt     <= '0;
            grant   <= '0;
            last    <= 4'd15;
        end else begin
            state   <= state_n;
            // a fresh request in the clearing cycle keeps the source pending
            pending <= (pending & ~clr) | req;
            cnt     <= cnt_n;
            grant   <= grant_n;
            last    <= last_n;
        end
    end

    assign green       = state == GREEN  ? N_REQ'(1) << grant : '0;
    assign yellow      = state == YELLOW ? N_REQ'(1) << grant : '0;
    assign busy        = state != IDLE;
    assign any_pending = |pending;
endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb_traffic_phase_scheduler: randomized and directed checks against a behavioural scheduler model
module tb_traffic_phase_scheduler;
    localparam int G = 5, Y = 2, A = 1;
    logic        clk = 0, reset = 1, tick = 0;
    logic [15:0] req = '0, green, yellow;
    logic        any_pending, busy;
    int          n_chk = 0, n_pass = 0;
    int          m_ph, m_cnt, m_last, m_grant, gt;
    logic [15:0] m_pend, prev_g;
    int          glog[$];
    bit          saw_idle;

    traffic_phase_scheduler dut (
        .clk(clk), .reset(reset), .tick(tick), .req(req),
        .green(green), .yellow(yellow), .any_pending(any_pending), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_ph = 0; m_cnt = 0; m_last = 15; m_grant = 0; m_pend = '0;
        prev_g = '0; gt = 0;
    endtask

    function automatic int pick();
        for (int k = 1; k <= 16; k++)
            if (m_pend[(m_last + k) % 16]) return (m_last + k) % 16;
        return -1;
    endfunction

    task automatic grant_next(inout logic [15:0] clr);
        int p;
        p = pick();
        if (p < 0) begin
            m_ph = 0;
        end else begin
            m_ph = 1; m_grant = p; m_last = p; clr[p] = 1'b1;
        end
        m_cnt = 0;
    endtask

    task automatic model_step(input logic [15:0] r, input logic t);
        logic [15:0] clr;
        int lim;
        clr = '0;
        if (m_ph == 0) begin
            if (m_pend != 0) grant_next(clr);
        end else if (t) begin
            lim = m_ph == 1 ? G : m_ph == 2 ? Y : A;
            if (m_cnt == lim - 1) begin
                if (m_ph == 3) grant_next(clr);
                else begin m_ph++; m_cnt = 0; end
            end else m_cnt++;
        end
        m_pend = (m_pend & ~clr) | r;
    endtask

    task automatic check_all();
        chk("green", green, m_ph == 1 ? 16'(1) << m_grant : 16'h0);
        chk("yellow", yellow, m_ph == 2 ? 16'(1) << m_grant : 16'h0);
        chk("busy", busy, m_ph != 0);
        chk("any_pending", any_pending, m_pend != 0);
        chk("exclusive", (|green) && (|yellow), 0);
        chk("onehot", $onehot0(green) && $onehot0(yellow), 1);
    endtask

    task automatic cyc(input logic [15:0] r, input logic t);
        req = r; tick = t;
        if (prev_g != 0 && t) gt++;
        @(posedge clk);
        if (reset) model_reset(); else model_step(r, t);
        #1;
        check_all();
        if (green != 0 && green != prev_g) glog.push_back($clog2(green));
        if (prev_g != 0 && green == 0) begin
            chk("green_len", gt, G);
            gt = 0;
        end
        prev_g = green;
        if (!busy) saw_idle = 1;
    endtask

    task automatic do_reset();
        reset = 1;
        cyc('0, 0);
        cyc('0, 0);
        reset = 0;
        glog.delete();
    endtask

    initial begin
        model_reset();
        do_reset();
        for (int i = 0; i < 20; i++) cyc('0, i[0]);
        chk("idle_busy", busy, 0);

        cyc(16'h0008, 0);
        cyc('0, 0);
        chk("latency_green", green, 16'h0008);
        for (int i = 0; i < 12; i++) cyc('0, 1);
        chk("single_done", busy, 0);
        chk("single_log", glog.size() == 1 && glog[0] == 3, 1);

        do_reset();
        for (int i = 0; i < 420; i++) cyc(16'hFFFF, i % 3 == 0);
        chk("all_count", glog.size() >= 17, 1);
        for (int i = 0; i < 17 && i < glog.size(); i++) chk("all_order", glog[i], i % 16);

        do_reset();
        cyc(16'h0010, 1);
        for (int i = 0; i < 12; i++) cyc('0, 1);
        glog.delete();
        cyc(16'h0024, 1);
        for (int i = 0; i < 30; i++) cyc('0, 1);
        chk("wrap_log", glog.size() == 2 && glog[0] == 5 && glog[1] == 2, 1);

        do_reset();
        cyc(16'h0080, 0);
        cyc('0, 0);
        saw_idle = 0;
        cyc(16'h0080, 1);
        for (int i = 0; i < 9; i++) cyc('0, 1);
        chk("regrant_log", glog.size() == 2 && glog[0] == 7 && glog[1] == 7, 1);
        chk("regrant_no_idle", saw_idle, 0);
        for (int i = 0; i < 10; i++) cyc('0, 1);

        do_reset();
        for (int i = 0; i < 1500; i++)
            cyc($urandom_range(0, 7) == 0 ? 16'($urandom) & 16'($urandom) & 16'($urandom) : 16'h0,
                1'($urandom_range(0, 1)));

        do_reset();
        cyc(16'h0001, 0);
        cyc('0, 0);
        cyc(16'h00F0, 0);
        for (int i = 0; i < 50 && yellow == 0; i++) cyc('0, 1);
        chk("mid_yellow", yellow, 16'h0001);
        chk("mid_pending", any_pending, 1);
        @(negedge clk);
        reset = 1;
        #1;
        chk("rst_green", green, 0);
        chk("rst_yellow", yellow, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pending", any_pending, 0);
        model_reset();
        cyc('0, 1);
        reset = 0;
        for (int i = 0; i < 10; i++) cyc('0, 1);
        chk("post_rst_idle", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
